// File: rtl/tdm_mux_8to1_if.sv
// Parallel-word handshake into the 8-to-1 TDM multiplexer.
// Producer drives d/d_valid, the mux answers with d_ready.
interface tdm_mux_8to1_if #(
  parameter int LANE_W = 1
);
  logic                  d_valid;
  logic                  d_ready;
  logic [8*LANE_W-1:0]   d;

  modport master (
    output d_valid,
    output d,
    input  d_ready
  );

  modport slave (
    input  d_valid,
    input  d,
    output d_ready
  );
endinterface

// File: rtl/tdm_mux_8to1.sv
// Time-division 8-to-1 mux: latches an 8-lane word, then emits
// one lane per cycle tagged with its slot index for the demux.
module tdm_mux_8to1 #(
  parameter int LANE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  tdm_mux_8to1_if.slave     in_if,
  output logic [LANE_W-1:0] y,
  output logic [2:0]        s,
  output logic              y_valid,
  output logic              frame_start,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [8*LANE_W-1:0] hold_q, hold_d;
  logic [LANE_W-1:0]   y_q, y_d;
  logic [2:0]          s_q, s_d;
  logic [2:0]          s_nxt;
  logic                vld_q, vld_d;
  logic                fs_q, fs_d;
  logic                last;
  logic                ready;
  logic                accept;
  int                  base;

  assign last   = (s_q == 3'd7);
  assign s_nxt  = s_q + 3'd1;
  assign accept = in_if.d_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready only when idle or on the final slot, so frames chain gap-free.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE: ready = !rst;
      SEND: ready = !rst && last;
      default: ready = 1'b0;
    endcase
  end

  assign in_if.d_ready = ready;

  always_comb begin
    hold_d = hold_q;
    y_d    = '0;
    s_d    = '0;
    vld_d  = 1'b0;
    fs_d   = 1'b0;
    base   = int'(s_nxt) * LANE_W;
    unique case (1'b1)
      accept: begin
        hold_d = in_if.d;
        y_d    = in_if.d[LANE_W-1:0];
        vld_d  = 1'b1;
        fs_d   = 1'b1;
      end
      (state_q == SEND && !last): begin
        y_d   = hold_q[base +: LANE_W];
        s_d   = s_nxt;
        vld_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      y_q    <= '0;
      s_q    <= '0;
      vld_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      y_q    <= y_d;
      s_q    <= s_d;
      vld_q  <= vld_d;
      fs_q   <= fs_d;
    end
  end

  assign y           = y_q;
  assign s           = s_q;
  assign y_valid     = vld_q;
  assign frame_start = fs_q;
  assign busy        = vld_q;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Bench for tdm_mux_8to1: LANE_W=1 and LANE_W=4 instances share
// control inputs and are checked against an accept-log model.
module tb_tdm_mux_8to1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_mux_8to1_if #(.LANE_W(1)) if1 ();
  tdm_mux_8to1_if #(.LANE_W(4)) if4 ();

  logic [0:0] y1;
  logic [3:0] y4;
  logic [2:0] s1, s4;
  logic       v1, v4, f1, f4, b1, b4;

  tdm_mux_8to1 #(.LANE_W(1)) u1 (
    .clk(clk), .rst(rst), .in_if(if1),
    .y(y1), .s(s1), .y_valid(v1),
    .frame_start(f1), .busy(b1)
  );

  tdm_mux_8to1 #(.LANE_W(4)) u4 (
    .clk(clk), .rst(rst), .in_if(if4),
    .y(y4), .s(s4), .y_valid(v4),
    .frame_start(f4), .busy(b4)
  );

  int checks = 0;
  int failures = 0;

  // Model: lane k of the last accepted word shows k cycles after its edge.
  int          cyc = 0;
  int          last_acc = -100;
  int          acc_cnt = 0;
  logic [7:0]  w1 = '0;
  logic [31:0] w4 = '0;

  function automatic bit m_ready();
    int k;
    k = cyc - last_acc;
    return !rst && !(k >= 0 && k <= 6);
  endfunction

  always @(posedge clk) begin
    bit r;
    r = m_ready();
    cyc++;
    if (rst) begin
      last_acc = -100;
    end else if (if1.d_valid && r) begin
      last_acc = cyc;
      acc_cnt++;
      w1 = if1.d;
      w4 = if4.d;
    end
  end

  function automatic logic [21:0] expv();
    int k;
    logic live, rdy, fs;
    logic [2:0] sk;
    logic [3:0] l1, l4;
    k    = cyc - last_acc;
    live = (k >= 0 && k <= 7);
    rdy  = !rst && !(k >= 0 && k <= 6);
    fs   = live && (k == 0);
    sk   = '0;
    l1   = '0;
    l4   = '0;
    if (live) begin
      sk = k[2:0];
      l1 = {3'b000, w1[k]};
      l4 = w4[k*4 +: 4];
    end
    return {rdy, live, live, fs, sk, l1,
            rdy, live, live, fs, sk, l4};
  endfunction

  function automatic logic [21:0] obsv();
    return {if1.d_ready, v1, b1, f1, s1, 3'b000, y1,
            if4.d_ready, v4, b4, f4, s4, y4};
  endfunction

  task automatic drive(input logic r, input logic v,
                       input logic [7:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r;
    if1.d_valid = v;
    if4.d_valid = v;
    if1.d = a;
    if4.d = b;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF);
    checks++;
    if (obsv() !== 22'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obsv(), 22'h0);
    end
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    checks++;
    if (obsv() !== expv() || v1 !== 1'b0 || if1.d_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obsv(), expv());
    end
  endtask

  task automatic test_single();
    logic [3:0] rb [8];
    logic [31:0] word;
    drive(1'b0, 1'b1, 8'b1011_0010, 32'h7654_3210);
    checks++;
    if (obsv() !== expv()) begin
      failures++;
      $display("FAIL single_pre got=%h exp=%h", obsv(), expv());
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 8'($urandom), $urandom);
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL single cyc=%0d got=%h exp=%h",
                 i + 1, obsv(), expv());
      end
      if (v4) begin
        rb[s4] = y4;
        checks++;
        if (y4 !== {1'b0, s4}) begin
          failures++;
          $display("FAIL lane4_value s=%0d got=%h exp=%h", s4, y4, s4);
        end
      end
    end
    word = {rb[7], rb[6], rb[5], rb[4], rb[3], rb[2], rb[1], rb[0]};
    checks++;
    if (word !== 32'h7654_3210) begin
      failures++;
      $display("FAIL demux_rebuild got=%h exp=%h", word, 32'h7654_3210);
    end
  endtask

  task automatic test_back_to_back();
    int a0, vcnt, fcnt, fpos0, fpos1;
    logic v;
    a0 = acc_cnt;
    vcnt = 0;
    fcnt = 0;
    fpos0 = -1;
    fpos1 = -1;
    for (int i = 0; i < 20; i++) begin
      v = (acc_cnt - a0) < 2;
      if (acc_cnt == a0)
        drive(1'b0, v, 8'hFF, 32'hFFFF_FFFF);
      else
        drive(1'b0, v, 8'h00, 32'h0000_0000);
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obsv(), expv());
      end
      if (v1) vcnt++;
      if (f1) begin
        if (fcnt == 0) fpos0 = i;
        else fpos1 = i;
        fcnt++;
      end
    end
    checks++;
    if (vcnt !== 16 || fcnt !== 2 || fpos1 - fpos0 !== 8) begin
      failures++;
      $display("FAIL b2b_frames valid=%0d fs=%0d gap=%0d exp 16/2/8",
               vcnt, fcnt, fpos1 - fpos0);
    end
  endtask

  task automatic test_backpressure();
    int a0, k;
    logic [7:0] o1;
    logic [31:0] o4;
    a0 = acc_cnt;
    o1 = 8'($urandom);
    o4 = $urandom;
    for (int i = 0; i < 22; i++) begin
      k = cyc - last_acc;
      if (acc_cnt == a0)
        drive(1'b0, 1'b1, o1, o4);
      else if (acc_cnt == a0 + 1 && k < 3)
        drive(1'b0, 1'b1, o1, o4);
      else if (acc_cnt == a0 + 1)
        drive(1'b0, 1'b1, 8'hA5, 32'hA5A5_A5A5);
      else
        drive(1'b0, 1'b0, 8'h00, 32'h0);
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h",
                 i, obsv(), expv());
      end
      if (v1) begin
        checks++;
        if (if1.d_ready !== (s1 == 3'd7)) begin
          failures++;
          $display("FAIL ready_at_s7 s=%0d got=%b", s1, if1.d_ready);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i == 0, 8'($urandom), $urandom);
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL midrst_pre got=%h exp=%h", obsv(), expv());
      end
      if (v1 && s1 == 3'd4) break;
    end
    checks++;
    if (s1 !== 3'd4) begin
      failures++;
      $display("FAIL midrst_reach got=%0d exp=4", s1);
    end
    drive(1'b1, 1'b1, 8'($urandom), $urandom);
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    checks++;
    if (obsv() !== 22'h0 || obsv() !== expv()) begin
      failures++;
      $display("FAIL midrst_zero got=%h exp=%h", obsv(), 22'h0);
    end
    drive(1'b0, 1'b1, 8'h3C, $urandom);
    checks++;
    if (if1.d_ready !== 1'b1 || v1 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_resume rdy=%b vld=%b exp 1/0",
               if1.d_ready, v1);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 8'($urandom), $urandom);
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL midrst_post cyc=%0d got=%h exp=%h",
                 i, obsv(), expv());
      end
    end
  endtask

  task automatic test_rst_valid_idle();
    drive(1'b1, 1'b1, 8'($urandom), $urandom);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    checks++;
    if (v1 !== 1'b0 || v4 !== 1'b0 || obsv() !== expv()) begin
      failures++;
      $display("FAIL rst_dv_idle got=%h exp=%h", obsv(), expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 50) == 0, ($urandom % 3) != 0,
            8'($urandom), $urandom);
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 i, obsv(), expv());
      end
    end
  endtask

  initial begin
    if1.d_valid = 1'b0;
    if4.d_valid = 1'b0;
    if1.d = '0;
    if4.d = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_rst_valid_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_mux_8to1.md
# tdm_mux_8to1

Time-division 8-to-1 multiplexer. It accepts an 8-lane parallel word through a valid/ready handshake and drives one lane per clock onto a single output. Each output lane is tagged with its 3-bit slot index, so a downstream 1-to-8 demultiplexer can use that index as its select and restore the word. This block is the gathering end of the team's 1-to-8 distribution path.

## Interface
- `LANE_W`, default 1: width of each lane in bits. Legal range is 1 to 16.
- `clk`  in  1  System clock. All state changes on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `d_valid`  in  1  Producer has a word on `d`.
- `d_ready`  out  1  Block can accept a word this cycle. Combinational from state. Forced to 0 while `rst`=1.
- `d`  in  8*LANE_W  Parallel word. Lane k is `d[k*LANE_W +: LANE_W]`.
- `y`  out  LANE_W  Serialized lane data. Registered.
- `s`  out  3  Slot index of the lane currently on `y`. Registered. Feeds the demux select.
- `y_valid`  out  1  `y`/`s` carry a live slot. Registered.
- `frame_start`  out  1  High in the slot-0 cycle of every frame. Registered.
- `busy`  out  1  High while a frame is in progress. Equals `y_valid`.

## Operation
- Clock is `clk`. Reset is `rst`: synchronous, active-high.
- Two states:
  - IDLE: no frame in progress.
  - SEND: a frame is being shifted out.
- Transfer rule: a word is accepted on an edge where `d_valid`=1 and `d_ready`=1. The full word is latched into an internal hold register.
- After a word is latched, changes on `d` have no effect until the next accept.
- `d_ready` is 1 in either of these cases:
  - state is IDLE;
  - state is SEND and `s`=7, so the next frame can start with no gap.
- `d_ready` is 0 in every other SEND cycle.
- IDLE transitions:
  - On accept: go to SEND, slot counter = 0.
  - Otherwise: stay in IDLE.
- SEND, while `s`<7: `s` increments by 1 each cycle.
- SEND, at `s`=7:
  - On accept: stay in SEND, wrap `s` to 0, take the new word.
  - Otherwise: go to IDLE.
- `y` always equals lane `s` of the hold register while `y_valid`=1.
- When `y_valid`=0, these outputs are held at 0: `y`, `s` and `frame_start`.
- Slot counter is 3 bits wide. Wrap from 7 to 0 happens only through the accept path, never by free-running.
- Frames are always a full 8 slots. No partial frames, no skipped slots.
- Reset values: `y`=0, `s`=0, `y_valid`=0, `frame_start`=0, `busy`=0, state=IDLE, hold register=0.
- Reset mid-frame: the frame is aborted.
  - Outputs read the reset values on the cycle after the `rst` edge.
  - The word is not resumed after reset releases.
- `d_valid` and `rst` high on the same edge: reset wins and the word is not accepted.
- `d_valid` high while `d_ready`=0: no effect. The producer must hold the word until it is accepted.

## Timing
- Accept on edge N gives:
  - `y_valid`=1, `frame_start`=1, `s`=0, `y`=lane 0, valid in the cycle after edge N.
  - Lane k is on `y` in the cycle after edge N+k.
- Latency from accept to first lane: 1 cycle. Frame length: 8 cycles.
- Back-to-back accept at `s`=7 on edge M: the cycle after edge M shows `s`=0, `frame_start`=1 with the new word. `y_valid` does not drop.
- Sustained throughput: 1 lane per cycle, i.e. one word every 8 cycles.
- No accept at `s`=7 on edge M: the cycle after edge M shows `y_valid`=0 and IDLE.
- From IDLE, the earliest new frame is the accept at that same edge M+1, giving a 1-cycle gap.
- All outputs are registered. The only combinational path from input to output is the `d_ready` state decode.

## Test plan
- Reset then single word, `LANE_W`=1, `d`=8'b1011_0010 accepted at edge 1:
  - Cycles 1-8 show `s`=0..7 and `y`=0,1,0,0,1,1,0,1.
  - `frame_start`=1 only in cycle 1.
  - Cycle 9 shows `y_valid`=0, `y`=0, `s`=0.
- Back-to-back words 8'hFF then 8'h00, `d_valid` held high:
  - 16 contiguous valid cycles.
  - `y`=1 for 8 cycles, then 0 for 8 cycles.
  - `frame_start` is high at cycles 1 and 9.
  - `d_ready` is high only at `s`=7.
- Backpressure: with `d_valid`=1 and `d` changing to 8'hA5 while `s`=3, the current frame's lanes are unchanged. 8'hA5 is accepted only at `s`=7.
- Reset mid-frame: assert `rst` at `s`=4.
  - Next cycle shows all outputs 0 and `d_ready`=0.
  - After release, `d_ready`=1 and a new word 8'h3C serializes from `s`=0.
- `LANE_W`=4, `d`=32'h7654_3210:
  - `y` reads 0,1,2,3,4,5,6,7 on `s`=0..7.
  - Feeding `y` and `s` into the 1-to-8 demux reproduces the original word at the end of the frame.
- Simultaneous `rst` and `d_valid` in IDLE: no accept, `y_valid` stays 0 the following cycle.
